pdp8ltc08q: RTL and testbench
=============================

# pdp8ltc08q

Queued, parametrised TC08 DECtape interface for the PDP-8/L Zynq design. It decodes the two TC08 IOT groups at configurable device codes and keeps TC08 status registers A and B. Each GO command is queued in a FIFO of snapshots for the ARM-side DECtape emulator, so the CPU can issue new commands while earlier ones are still being serviced. Completion is posted through a set-only register, so ARM writes cannot overwrite bits the CPU has just changed.

## Interface
- DEVA, 6'o76: device code of the status-A group (IOT 6xx0..6xx7).
- DEVB, 6'o77: device code of the status-B group.
- QDEPTH, 4: command FIFO depth, power of two, 2..16.
- VERSION, 12'h003: returned in the ID register.
- CLOCK  in  1  sole clock.
- RESET  in  1  synchronous, active-high; full reset including `enable`.
- BINIT  in  1  PDP-8/L bus init; clears all state except `enable`.
- CSTEP  in  1  IOP-sequencer step qualifier; IOPs are sampled only when it is high.
- armwrite  in  1  ARM register write strobe.
- armraddr, armwaddr  in  2  ARM read and write register index.
- armwdata  in  32  ARM write data.
- armrdata  out  32  ARM read data (combinational).
- iopstart, iopstop  in  1  leading and trailing edges of an IOP.
- ioopcode  in  12  current IOT opcode.
- cputodev  in  12  AC contents from the CPU.
- devtocpu  out  12  data onto the CPU bus; reset value 0.
- AC_CLEAR, IO_SKIP  out  1  reset value 0.
- INT_RQST  out  1  `(B[11]|B[00]) & A[02]` (combinational).

## Operation
- ARM register 0 (read-only): `{16'h5443, 4'd1, VERSION}`.
- ARM register 1 (read/write): `{enable, 3'b0, B, qne, 3'b0, A}`, where `qne` = queue not empty. A write loads `enable`, B and A; the `qne` bit is ignored on write.
- ARM register 2, read: `{valid, 3'b0, count[3:0], 9'b0, B[05:03], A}`, showing the FIFO head. On a write, the head is popped when `armwdata[31]` is set; a write to an empty FIFO is a no-op.
- ARM register 3, write: ORs `armwdata[11:00]` into B (set-only), then forces B[05:03] back to their prior value.
- ARM register 3, read: statistics (see Configuration).
- IOPs are processed only when `CSTEP & iopstart & enable`.
- DEVA group, bit 2 set:
  - A ← (bit1 ? 0 : A) ^ (AC & 7774).
  - AC[00]=0 clears B[00]; AC[01]=0 clears B[11:08].
  - AC_CLEAR ← 1.
  - If the new A[07] (GO) is set, push `{B[05:03], newA}`.
- DEVA group, bit 2 clear and bit 1 set: A ← 0.
- DEVA group, bit 0: devtocpu ← A (the pre-update value).
- DEVB group:
  - bit 2: B[05:03] ← AC[05:03]; AC_CLEAR ← 1.
  - bit 1: devtocpu ← B.
  - bit 0: IO_SKIP ← B[11]|B[00].
- GO pushed while the FIFO is full: nothing is pushed; B[08] (timing error) is set.
- `CSTEP & iopstop` and no active `iopstart`: AC_CLEAR, IO_SKIP and devtocpu ← 0.
- Opcodes in any other device group are ignored, and the outputs are left unchanged.

## Timing
- State updates one CLOCK after the qualifying edge. Outputs hold until the matching iopstop step.
- Priority order: RESET > BINIT > ARM write to register 1 > IOP.
  - An ARM register-1 write in the same cycle as an IOP causes the IOP to be dropped.
- ARM writes to register 2 or 3 combine with an IOP in the same cycle:
  - Simultaneous push and pop: count is unchanged; if the FIFO was full, the push succeeds.
  - A register-3 set and an IOP clear of the same B bit: the set wins.
- FIFO pointers wrap modulo QDEPTH; count ranges 0..QDEPTH.
- RESET or BINIT mid-IOP:
  - Outputs and the FIFO are cleared at once.
  - A later iopstop is harmless.

## Configuration
- `PDP8LTC08Q_STATS_EN` defined:
  - Register 3 reads `{gocount[15:0], 4'b0, ovfcount[11:0]}`.
  - `gocount` counts accepted pushes and wraps at 16 bits.
  - `ovfcount` counts FIFO-full drops and saturates at 12'hFFF.
  - Both counters clear on RESET or BINIT, or on a register-3 write with `armwdata[31]`=1.
- `PDP8LTC08Q_STATS_EN` undefined: register 3 reads 0, and the counters are not synthesised.

## Structure
- Package `pdp8ltc08q_pkg` holds:
  - ARM register indices.
  - Status bit positions: GO=7, IE=2, ERR=11, TIM=8, DONE=0.
  - The ID constant 16'h5443.
  - A typedef for the 15-bit queue entry.
- Sub-module `pdp8ltc08qfifo`:
  - Synchronous FIFO parameterised by QDEPTH, with push, pop, clear, head, count, full and empty.
  - A simultaneous push and pop when full is legal.

## Test plan
- enable=1, AC=0200, IOT 6764 → A=0200, AC_CLEAR=1, register 2 reads valid with count 1 and A=0200; iopstop → AC_CLEAR=0.
- Five GOs with QDEPTH=4 → count=4 and B[08]=1; with STATS, register 3 reads `gocount`=4, `ovfcount`=1.
- FIFO full; GO push and a register-2 pop in the same cycle → count stays 4, and the new entry is at the tail.
- A=0004, register 3 write 0001 → INT_RQST=1; IOT 6771 → IO_SKIP=1; IOT 6764 with AC=0000 → B[00]=0, INT_RQST=0.
- enable=0, IOT 6764 → no state change; BINIT mid-IOP → A=B=0, FIFO empty, enable kept; RESET → enable=0.

Source files
------------

// File: rtl/pdp8ltc08q_pkg.sv
`default_nettype none
// ============================================================================
// Module   : pdp8ltc08q_pkg
// Purpose  : Shared constants and types for the queued TC08 DECtape interface:
//            ARM register indices, status bit positions, the ID constant and
//            the 15-bit command queue entry {B[05:03], A[11:00]}.
// Revision : 1.0 - initial release
// ============================================================================
package pdp8ltc08q_pkg;

  // ARM-side register indices
  localparam logic [1:0] c_reg_id   = 2'd0;
  localparam logic [1:0] c_reg_stat = 2'd1;
  localparam logic [1:0] c_reg_fifo = 2'd2;
  localparam logic [1:0] c_reg_set  = 2'd3;

  // Status bit positions (bit 0 is the LSB)
  localparam int c_bit_go   = 7;   // A: GO
  localparam int c_bit_ie   = 2;   // A: interrupt enable
  localparam int c_bit_err  = 11;  // B: error flag
  localparam int c_bit_tim  = 8;   // B: timing error
  localparam int c_bit_done = 0;   // B: DECtape flag (done)

  localparam logic [15:0] c_id_code = 16'h5443;

  // Queue entry: unit select B[05:03] above a copy of status A
  typedef logic [14:0] qentry_t;

endpackage
`default_nettype wire

// File: rtl/pdp8ltc08qfifo.sv
`default_nettype none
// ============================================================================
// Module   : pdp8ltc08qfifo
// Purpose  : Synchronous command FIFO of QDEPTH (power of two) entries.
//            A push while full is accepted only if a pop happens in the same
//            cycle; a pop while empty is ignored.
// Ports    : clk_i, rst_i (sync, active-high), clear_i (sync flush),
//            push_i/data_i, pop_i, head_o (oldest entry), count_o,
//            full_o, empty_o.
// Revision : 1.0 - initial release
// ============================================================================
module pdp8ltc08qfifo
  import pdp8ltc08q_pkg::*;
#(
  parameter int QDEPTH = 4
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic                         clear_i,
  input  logic                         push_i,
  input  logic                         pop_i,
  input  qentry_t                      data_i,
  output qentry_t                      head_o,
  output logic [$clog2(QDEPTH+1)-1:0]  count_o,
  output logic                         full_o,
  output logic                         empty_o
);

  localparam int c_pw = $clog2(QDEPTH);
  localparam int c_cw = $clog2(QDEPTH+1);

  qentry_t           mem_q [QDEPTH];
  logic [c_pw-1:0]   rd_q, wr_q;
  logic [c_cw-1:0]   cnt_q;
  logic              w_push_ok, w_pop_ok;

  assign full_o    = (cnt_q == c_cw'(QDEPTH));
  assign empty_o   = (cnt_q == '0);
  assign w_pop_ok  = pop_i & ~empty_o;
  // When full, the slot being written is the one being popped this cycle.
  assign w_push_ok = push_i & (~full_o | w_pop_ok);
  assign head_o    = mem_q[rd_q];
  assign count_o   = cnt_q;

  always_ff @(posedge clk_i) begin
    if (w_push_ok) begin
      mem_q[wr_q] <= data_i;
    end
  end

  // Pointers wrap naturally because QDEPTH is a power of two.
  always_ff @(posedge clk_i) begin
    if (rst_i || clear_i) begin
      rd_q  <= '0;
      wr_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (w_push_ok) wr_q <= wr_q + c_pw'(1);
      if (w_pop_ok)  rd_q <= rd_q + c_pw'(1);
      case ({w_push_ok, w_pop_ok})
        2'b10:   cnt_q <= cnt_q + c_cw'(1);
        2'b01:   cnt_q <= cnt_q - c_cw'(1);
        default: cnt_q <= cnt_q;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: rtl/pdp8ltc08q.sv
`default_nettype none
// ============================================================================
// Module   : pdp8ltc08q
// Purpose  : Queued TC08 DECtape interface. Decodes the status-A (DEVA) and
//            status-B (DEVB) IOT groups, holds status registers A and B and
//            queues every GO command as {B[05:03], A} for the ARM emulator.
//            ARM register 3 writes are set-only so they cannot undo CPU
//            updates made in the same cycle.
// Ports    : CLOCK, RESET (sync, full reset), BINIT (clears all but enable),
//            CSTEP (IOP step qualifier), arm* (ARM register bus, read data
//            combinational), iopstart/iopstop, ioopcode, cputodev (AC),
//            devtocpu, AC_CLEAR, IO_SKIP (registered), INT_RQST (comb).
// Options  : `PDP8LTC08Q_STATS_EN adds GO / overflow counters on register 3.
// Revision : 1.0 - initial release
// ============================================================================
module pdp8ltc08q
  import pdp8ltc08q_pkg::*;
#(
  parameter logic [5:0]  DEVA    = 6'o76,
  parameter logic [5:0]  DEVB    = 6'o77,
  parameter int          QDEPTH  = 4,
  parameter logic [11:0] VERSION = 12'h003
) (
  input  logic        CLOCK,
  input  logic        RESET,
  input  logic        BINIT,
  input  logic        CSTEP,
  input  logic        armwrite,
  input  logic [1:0]  armraddr,
  input  logic [1:0]  armwaddr,
  input  logic [31:0] armwdata,
  output logic [31:0] armrdata,
  input  logic        iopstart,
  input  logic        iopstop,
  input  logic [11:0] ioopcode,
  input  logic [11:0] cputodev,
  output logic [11:0] devtocpu,
  output logic        AC_CLEAR,
  output logic        IO_SKIP,
  output logic        INT_RQST
);

  localparam int c_cw = $clog2(QDEPTH+1);

  logic        enable_q, enable_d;
  logic [11:0] a_q, a_d;
  logic [11:0] b_q, b_d;
  logic [11:0] dtc_q, dtc_d;
  logic        acclr_q, acclr_d;
  logic        skip_q, skip_d;

  logic            w_wr1, w_wr2, w_wr3, w_pop, w_iop, w_stop;
  logic            w_deva, w_devb;
  logic            w_push, w_ovf;
  logic [11:0]     w_new_a;
  qentry_t         w_head;
  logic [c_cw-1:0] w_count;
  logic            w_full, w_empty;
  logic [31:0]     w_stats;
  logic            w_unused_bits;

  assign w_wr1  = armwrite && (armwaddr == c_reg_stat);
  assign w_wr2  = armwrite && (armwaddr == c_reg_fifo);
  assign w_wr3  = armwrite && (armwaddr == c_reg_set);
  assign w_pop  = w_wr2 & armwdata[31];
  // A register-1 write owns A, B and enable this cycle, so the IOP is lost.
  assign w_iop  = CSTEP & iopstart & enable_q & ~w_wr1;
  assign w_stop = CSTEP & iopstop & ~iopstart;
  assign w_deva = (ioopcode[11:9] == 3'o6) && (ioopcode[8:3] == DEVA);
  assign w_devb = (ioopcode[11:9] == 3'o6) && (ioopcode[8:3] == DEVB);

  assign w_unused_bits = ^{armwdata[30:28], armwdata[15:12]};

  always_comb begin
    enable_d = enable_q;
    a_d      = a_q;
    b_d      = b_q;
    dtc_d    = dtc_q;
    acclr_d  = acclr_q;
    skip_d   = skip_q;
    w_push   = 1'b0;
    w_ovf    = 1'b0;
    w_new_a  = (ioopcode[1] ? 12'o0000 : a_q) ^ (cputodev & 12'o7774);

    if (w_wr1) begin
      enable_d = armwdata[31];
      b_d      = armwdata[27:16];
      a_d      = armwdata[11:0];
    end

    if (w_iop) begin
      if (w_deva) begin
        if (ioopcode[0]) dtc_d = a_q;
        if (ioopcode[2]) begin
          a_d     = w_new_a;
          acclr_d = 1'b1;
          if (!cputodev[0]) b_d[c_bit_done] = 1'b0;
          if (!cputodev[1]) b_d[11:8]       = 4'b0000;
          if (w_new_a[c_bit_go]) begin
            // Full queue only accepts the push if the ARM pops this cycle.
            if (w_full && !w_pop) w_ovf  = 1'b1;
            else                  w_push = 1'b1;
          end
        end else if (ioopcode[1]) begin
          a_d = 12'o0000;
        end
      end else if (w_devb) begin
        if (ioopcode[2]) begin
          b_d[5:3] = cputodev[5:3];
          acclr_d  = 1'b1;
        end
        if (ioopcode[1]) dtc_d  = b_q;
        if (ioopcode[0]) skip_d = b_q[c_bit_err] | b_q[c_bit_done];
      end
    end else if (w_stop) begin
      dtc_d   = 12'o0000;
      acclr_d = 1'b0;
      skip_d  = 1'b0;
    end

    // Timing error is raised after the AC-driven clears so it stays visible.
    if (w_ovf) b_d[c_bit_tim] = 1'b1;

    // Set-only ARM update applied last so it beats a same-cycle IOP clear;
    // the unit-select field B[05:03] is never touched by this path.
    if (w_wr3) begin
      b_d[11:6] = b_d[11:6] | armwdata[11:6];
      b_d[2:0]  = b_d[2:0]  | armwdata[2:0];
    end
  end

  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      enable_q <= 1'b0;
      a_q      <= '0;
      b_q      <= '0;
      dtc_q    <= '0;
      acclr_q  <= 1'b0;
      skip_q   <= 1'b0;
    end else if (BINIT) begin
      a_q      <= '0;
      b_q      <= '0;
      dtc_q    <= '0;
      acclr_q  <= 1'b0;
      skip_q   <= 1'b0;
    end else begin
      enable_q <= enable_d;
      a_q      <= a_d;
      b_q      <= b_d;
      dtc_q    <= dtc_d;
      acclr_q  <= acclr_d;
      skip_q   <= skip_d;
    end
  end

  pdp8ltc08qfifo #(
    .QDEPTH (QDEPTH)
  ) u_fifo (
    .clk_i   (CLOCK),
    .rst_i   (RESET),
    .clear_i (BINIT),
    .push_i  (w_push),
    .pop_i   (w_pop),
    .data_i  ({b_q[5:3], w_new_a}),
    .head_o  (w_head),
    .count_o (w_count),
    .full_o  (w_full),
    .empty_o (w_empty)
  );

`ifdef PDP8LTC08Q_STATS_EN
  logic [15:0] gocnt_q;
  logic [11:0] ovfcnt_q;

  always_ff @(posedge CLOCK) begin
    if (RESET || BINIT || (w_wr3 && armwdata[31])) begin
      gocnt_q  <= '0;
      ovfcnt_q <= '0;
    end else begin
      if (w_push) gocnt_q <= gocnt_q + 16'd1;
      if (w_ovf && (ovfcnt_q != 12'hFFF)) ovfcnt_q <= ovfcnt_q + 12'd1;
    end
  end

  assign w_stats = {gocnt_q, 4'b0000, ovfcnt_q};
`else
  assign w_stats = 32'h0000_0000;
`endif

  always_comb begin
    armrdata = 32'h0000_0000;
    case (armraddr)
      c_reg_id:   armrdata = {c_id_code, 4'd1, VERSION};
      c_reg_stat: armrdata = {enable_q, 3'b000, b_q, ~w_empty, 3'b000, a_q};
      c_reg_fifo: armrdata = {~w_empty, 3'b000, 4'(w_count), 9'b0, w_head};
      c_reg_set:  armrdata = w_stats;
      default:    armrdata = 32'h0000_0000;
    endcase
  end

  assign devtocpu = dtc_q;
  assign AC_CLEAR = acclr_q;
  assign IO_SKIP  = skip_q;
  assign INT_RQST = (b_q[c_bit_err] | b_q[c_bit_done]) & a_q[c_bit_ie];

endmodule
`default_nettype wire

// File: tb/tb_pdp8ltc08q.sv
`default_nettype none
// ============================================================================
// Module   : tb_pdp8ltc08q
// Purpose  : Self-checking bench for pdp8ltc08q (QDEPTH=4). A vector table
//            drives IOTs and checks status and outputs; queued GO entries
//            are predicted into a scoreboard queue and compared as the FIFO
//            head is drained over ARM register 2.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pdp8ltc08q;

  logic        CLOCK = 1'b0;
  logic        RESET = 1'b1;
  logic        BINIT = 1'b0;
  logic        CSTEP = 1'b0;
  logic        armwrite = 1'b0;
  logic [1:0]  armraddr = 2'd0;
  logic [1:0]  armwaddr = 2'd0;
  logic [31:0] armwdata = 32'd0;
  logic [31:0] armrdata;
  logic        iopstart = 1'b0;
  logic        iopstop = 1'b0;
  logic [11:0] ioopcode = 12'd0;
  logic [11:0] cputodev = 12'd0;
  logic [11:0] devtocpu;
  logic        AC_CLEAR, IO_SKIP, INT_RQST;

  int errors = 0;
  int checks = 0;

  logic [14:0] exp_q [$];

  typedef struct {
    logic [11:0] op;
    logic [11:0] ac;
    logic [11:0] ea;
    logic [11:0] eb;
    logic [11:0] edtc;
    logic        eclr;
    logic        eskip;
    logic [3:0]  ecnt;
    logic        go;
  } vec_t;

  vec_t vecs [8];

  always #5 CLOCK = ~CLOCK;

  pdp8ltc08q #(
    .DEVA    (6'o76),
    .DEVB    (6'o77),
    .QDEPTH  (4),
    .VERSION (12'h003)
  ) dut (
    .CLOCK    (CLOCK),
    .RESET    (RESET),
    .BINIT    (BINIT),
    .CSTEP    (CSTEP),
    .armwrite (armwrite),
    .armraddr (armraddr),
    .armwaddr (armwaddr),
    .armwdata (armwdata),
    .armrdata (armrdata),
    .iopstart (iopstart),
    .iopstop  (iopstop),
    .ioopcode (ioopcode),
    .cputodev (cputodev),
    .devtocpu (devtocpu),
    .AC_CLEAR (AC_CLEAR),
    .IO_SKIP  (IO_SKIP),
    .INT_RQST (INT_RQST)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, want %0h", name, act, exp);
    end
  endtask

  // One clock of stimulus; everything is released 1 time unit after the edge.
  task automatic step(input logic st, input logic sp, input logic [11:0] op,
                      input logic [11:0] ac, input logic wr, input logic [1:0] wa,
                      input logic [31:0] wd);
    CSTEP    = st | sp;
    iopstart = st;
    iopstop  = sp;
    ioopcode = op;
    cputodev = ac;
    armwrite = wr;
    armwaddr = wa;
    armwdata = wd;
    @(posedge CLOCK);
    #1;
    CSTEP    = 1'b0;
    iopstart = 1'b0;
    iopstop  = 1'b0;
    armwrite = 1'b0;
  endtask

  task automatic iop(input logic [11:0] op, input logic [11:0] ac);
    step(1'b1, 1'b0, op, ac, 1'b0, 2'd0, 32'd0);
  endtask

  task automatic stop();
    step(1'b0, 1'b1, 12'd0, 12'd0, 1'b0, 2'd0, 32'd0);
  endtask

  task automatic awr(input logic [1:0] a, input logic [31:0] d);
    step(1'b0, 1'b0, 12'd0, 12'd0, 1'b1, a, d);
  endtask

  task automatic rd(input logic [1:0] a, output logic [31:0] d);
    armraddr = a;
    #1;
    d = armrdata;
  endtask

  // Compare each FIFO head against the scoreboard, then pop it.
  task automatic drain(input int n);
    logic [31:0] d;
    logic [14:0] e;
    for (int k = 0; k < n; k++) begin
      rd(2'd2, d);
      if (exp_q.size() == 0) begin
        chk("scoreboard underflow", 32'd0, 32'd1);
      end else begin
        e = exp_q.pop_front();
        chk($sformatf("head%0d valid", k), {31'd0, d[31]}, 32'd1);
        chk($sformatf("head%0d entry", k), {17'd0, d[14:0]}, {17'd0, e});
      end
      awr(2'd2, 32'h8000_0000);
    end
    rd(2'd2, d);
    chk("drained valid", {31'd0, d[31]}, 32'd0);
  endtask

  initial begin
    logic [31:0] d;

    vecs[0] = '{op:12'o6764, ac:12'o0200, ea:12'o0200, eb:12'o0000, edtc:12'o0000, eclr:1'b1, eskip:1'b0, ecnt:4'd1, go:1'b1};
    vecs[1] = '{op:12'o6774, ac:12'o0050, ea:12'o0200, eb:12'o0050, edtc:12'o0000, eclr:1'b1, eskip:1'b0, ecnt:4'd1, go:1'b0};
    vecs[2] = '{op:12'o6772, ac:12'o0000, ea:12'o0200, eb:12'o0050, edtc:12'o0050, eclr:1'b0, eskip:1'b0, ecnt:4'd1, go:1'b0};
    vecs[3] = '{op:12'o6765, ac:12'o0203, ea:12'o0000, eb:12'o0050, edtc:12'o0200, eclr:1'b1, eskip:1'b0, ecnt:4'd1, go:1'b0};
    vecs[4] = '{op:12'o6764, ac:12'o0204, ea:12'o0204, eb:12'o0050, edtc:12'o0000, eclr:1'b1, eskip:1'b0, ecnt:4'd2, go:1'b1};
    vecs[5] = '{op:12'o6766, ac:12'o0010, ea:12'o0010, eb:12'o0050, edtc:12'o0000, eclr:1'b1, eskip:1'b0, ecnt:4'd2, go:1'b0};
    vecs[6] = '{op:12'o6762, ac:12'o0000, ea:12'o0000, eb:12'o0050, edtc:12'o0000, eclr:1'b0, eskip:1'b0, ecnt:4'd2, go:1'b0};
    vecs[7] = '{op:12'o6754, ac:12'o0200, ea:12'o0000, eb:12'o0050, edtc:12'o0000, eclr:1'b0, eskip:1'b0, ecnt:4'd2, go:1'b0};

    // Reset state
    repeat (2) @(posedge CLOCK);
    #1;
    RESET = 1'b0;
    rd(2'd1, d);
    chk("reset reg1", d, 32'h0000_0000);
    chk("reset outputs", {19'd0, devtocpu, AC_CLEAR, IO_SKIP, INT_RQST}, 32'd0);
    rd(2'd0, d);
    chk("id reg", d, 32'h5443_1003);
    rd(2'd2, d);
    chk("reset fifo", d[31:24], 8'h00);

    awr(2'd1, 32'h8000_0000);

    // Table-driven IOT vectors
    for (int i = 0; i < 8; i++) begin
      iop(vecs[i].op, vecs[i].ac);
      if (vecs[i].go) exp_q.push_back({vecs[i].eb[5:3], vecs[i].ea});
      rd(2'd1, d);
      chk($sformatf("v%0d A", i), {20'd0, d[11:0]}, {20'd0, vecs[i].ea});
      chk($sformatf("v%0d B", i), {20'd0, d[27:16]}, {20'd0, vecs[i].eb});
      rd(2'd2, d);
      chk($sformatf("v%0d count", i), {28'd0, d[27:24]}, {28'd0, vecs[i].ecnt});
      chk($sformatf("v%0d devtocpu", i), {20'd0, devtocpu}, {20'd0, vecs[i].edtc});
      chk($sformatf("v%0d clr/skip", i), {30'd0, AC_CLEAR, IO_SKIP},
          {30'd0, vecs[i].eclr, vecs[i].eskip});
      stop();
      chk($sformatf("v%0d after stop", i), {18'd0, devtocpu, AC_CLEAR, IO_SKIP}, 32'd0);
    end
    drain(2);

    // Overflow: five GOs into a 4-deep queue
    awr(2'd3, 32'h8000_0000);
    for (int i = 0; i < 5; i++) begin
      iop(12'o6766, 12'o0200);
      if (i < 4) exp_q.push_back({3'b101, 12'o0200});
      stop();
    end
    rd(2'd2, d);
    chk("ovf count", {28'd0, d[27:24]}, 32'd4);
    rd(2'd1, d);
    chk("ovf B", {20'd0, d[27:16]}, {20'd0, 12'o0450});
    rd(2'd3, d);
`ifdef PDP8LTC08Q_STATS_EN
    chk("stats", d, {16'd4, 4'd0, 12'd1});
`else
    chk("stats", d, 32'd0);
`endif

    // Full queue: push and pop in the same cycle
    awr(2'd1, 32'h8028_0080);
    rd(2'd2, d);
    chk("pre-pop head", {17'd0, d[14:0]}, {17'd0, exp_q[0]});
    step(1'b1, 1'b0, 12'o6766, 12'o0300, 1'b1, 2'd2, 32'h8000_0000);
    void'(exp_q.pop_front());
    exp_q.push_back({3'b101, 12'o0300});
    stop();
    rd(2'd2, d);
    chk("push+pop count", {28'd0, d[27:24]}, 32'd4);
    rd(2'd1, d);
    chk("push+pop B", {20'd0, d[27:16]}, {20'd0, 12'o0050});
    drain(4);

    // Interrupt request, skip and set-only register 3
    awr(2'd1, 32'h8000_0004);
    awr(2'd3, 32'h0000_0001);
    chk("int set", {31'd0, INT_RQST}, 32'd1);
    iop(12'o6771, 12'o0000);
    chk("skip", {31'd0, IO_SKIP}, 32'd1);
    stop();
    iop(12'o6764, 12'o0000);
    rd(2'd1, d);
    chk("done clear B", {20'd0, d[27:16]}, 32'd0);
    chk("int clear", {31'd0, INT_RQST}, 32'd0);
    stop();
    step(1'b1, 1'b0, 12'o6764, 12'o0000, 1'b1, 2'd3, 32'h0000_0001);
    rd(2'd1, d);
    chk("set beats clear", {20'd0, d[27:16]}, 32'd1);
    stop();
    awr(2'd3, 32'h0000_0038);
    rd(2'd1, d);
    chk("B[5:3] protected", {20'd0, d[27:16]}, 32'd1);

    // Disabled interface ignores IOPs
    awr(2'd1, 32'h0000_0000);
    iop(12'o6764, 12'o0200);
    rd(2'd1, d);
    chk("disabled A", {20'd0, d[11:0]}, 32'd0);
    chk("disabled clr", {31'd0, AC_CLEAR}, 32'd0);
    stop();

    // Register-1 write drops a same-cycle IOP
    awr(2'd1, 32'h8000_0000);
    step(1'b1, 1'b0, 12'o6766, 12'o0200, 1'b1, 2'd1, 32'h8000_0000);
    rd(2'd1, d);
    chk("dropped iop", d, 32'h8000_0000);
    chk("dropped clr", {31'd0, AC_CLEAR}, 32'd0);

    // BINIT mid-IOP
    iop(12'o6766, 12'o0200);
    stop();
    iop(12'o6774, 12'o0000);
    chk("pre-binit clr", {31'd0, AC_CLEAR}, 32'd1);
    BINIT = 1'b1;
    @(posedge CLOCK);
    #1;
    BINIT = 1'b0;
    exp_q.delete();
    rd(2'd1, d);
    chk("binit reg1", d, 32'h8000_0000);
    chk("binit clr", {31'd0, AC_CLEAR}, 32'd0);
    rd(2'd2, d);
    chk("binit fifo", d[31:24], 8'h00);
    stop();
    rd(2'd1, d);
    chk("late stop", {d, 17'd0, devtocpu, AC_CLEAR, IO_SKIP} == {32'h8000_0000, 31'd0} ? 32'd1 : 32'd0, 32'd1);

    // Full reset clears enable
    RESET = 1'b1;
    @(posedge CLOCK);
    #1;
    RESET = 1'b0;
    rd(2'd1, d);
    chk("reset enable", d, 32'h0000_0000);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
